// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state types and bit-timing helper
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Integer division: any fractional part of the ratio is dropped.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    localparam int DEFAULT_CLK_FREQ     = 50000000;
    localparam int DEFAULT_BAUD_RATE    = 9600;
    localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE);

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with input synchronizer and mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1;
    logic             sync2;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt       <= '0;
                    bit_idx   <= '0;
                    frame_err <= 1'b0;
                    if (!sync2) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at its midpoint was a glitch.
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (frame_err) begin
                        if (sync2) begin
                            state <= RX_IDLE;
                        end
                    end else if (cnt == BIT_END) begin
                        cnt <= '0;
                        // Leaving at mid-stop leaves half a bit to spot a back-to-back start.
                        if (sync2) begin
                            data  <= shift;
                            valid <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver_test.sv
// rtl/uart_transceiver_test.sv - key-triggered UART transmitter plus receiver with LED mirror
module uart_transceiver_test
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int         BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter logic [7:0] TEST_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1,
    output logic       txd,
    output logic       tx_busy,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] leds
);

    localparam int              CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int              CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END      = CNT_W'(CLKS_PER_BIT - 1);

    logic             key_s1;
    logic             key_s2;
    logic             key_prev;
    logic             key_edge;
    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit_idx;
    logic [7:0]       tx_shift;

    // Presetting to 1 keeps a key held through reset from looking like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
        end else begin
            key_s1   <= key1;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign key_edge = key_s2 & ~key_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd        <= 1'b1;
                    tx_busy    <= 1'b0;
                    tx_cnt     <= '0;
                    tx_bit_idx <= '0;
                    if (key_edge) begin
                        tx_state <= TX_START;
                        tx_shift <= TEST_BYTE;
                        txd      <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt     <= '0;
                        tx_bit_idx <= '0;
                        txd        <= tx_shift[0];
                        tx_state   <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_bit_idx == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 1'b1;
                            txd        <= tx_shift[1];
                            tx_shift   <= {1'b1, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .data (rx_data),
        .valid(rx_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= '0;
        end else if (rx_valid) begin
            leds <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_transceiver_test.sv
// tb/tb_uart_transceiver_test.sv - randomized self-checking bench for the UART loopback block
module tb_uart_transceiver_test;

    localparam int         CLK_FREQ  = 50000000;
    localparam int         BAUD_RATE = 1000000;
    localparam logic [7:0] TEST_BYTE = 8'hA5;
    localparam int         CPB       = CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key1 = 1'b0;
    logic       drv_rxd = 1'b1;
    logic       loop_en = 1'b0;
    logic       rxd;
    logic       txd;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] leds;

    int         n_checks = 0;
    int         n_fail = 0;
    int         long_pulses = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] last_good = 8'h00;

    assign rxd = loop_en ? txd : drv_rxd;

    uart_transceiver_test #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .TEST_BYTE(TEST_BYTE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key1    (key1),
        .txd     (txd),
        .tx_busy (tx_busy),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rx_valid) got_q.push_back(rx_data);
        if (rx_valid && prev_valid) long_pulses++;
        prev_valid = rx_valid;
    end

    // Position i of an 8N1 frame: start bit, eight data bits LSB first, stop bit.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            drv_rxd = (i == 9) ? stop_bit : frame_bit(b, i);
            repeat (CPB) @(negedge clk);
        end
        drv_rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b exp=1", txd); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds got=%h exp=00", leds); end
        rst = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_loopback_send(input int press_at, input string name);
        int   lat;
        int   valid_k;
        logic bad;
        logic extra;
        loop_en = 1'b1;
        got_q.delete();
        lat = 0;
        valid_k = -1;
        key1 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 2) key1 = 1'b0;
            if (txd === 1'b0) begin
                lat = n;
                break;
            end
        end
        key1 = 1'b0;
        n_checks++;
        if (lat == 0 || lat > 4) begin
            n_fail++;
            $display("FAIL %s_start_latency got=%0d exp=1..4", name, lat);
        end
        if (lat != 0) begin
            bad = 1'b0;
            for (int k = 0; k < 10 * CPB; k++) begin
                if (k > 0) @(negedge clk);
                if (k == press_at) key1 = 1'b1;
                if (k == press_at + 2) key1 = 1'b0;
                if (txd !== frame_bit(TEST_BYTE, k / CPB) || tx_busy !== 1'b1) bad = 1'b1;
                if (valid_k < 0 && got_q.size() > 0) valid_k = k;
                if (k % CPB == CPB - 1) begin
                    n_checks++;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL %s_bit%0d txd/busy got=%b/%b exp=%b/1", name, k / CPB, txd, tx_busy,
                                 frame_bit(TEST_BYTE, k / CPB));
                    end
                    bad = 1'b0;
                end
            end
            @(negedge clk);
            n_checks++;
            if (tx_busy !== 1'b0 || txd !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_busy_fall busy/txd got=%b/%b exp=0/1", name, tx_busy, txd);
            end
            n_checks++;
            if (valid_k < 9 * CPB || valid_k >= 10 * CPB) begin
                n_fail++;
                $display("FAIL %s_valid_time got=%0d exp=%0d..%0d", name, valid_k, 9 * CPB, 10 * CPB - 1);
            end
        end
        extra = 1'b0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra) begin n_fail++; $display("FAIL %s_no_second_frame got=activity exp=idle", name); end
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== TEST_BYTE) begin
            n_fail++;
            $display("FAIL %s_rx_count got=%0d exp=1 byte %h", name, got_q.size(), TEST_BYTE);
        end
        n_checks++;
        if (rx_data !== TEST_BYTE || leds !== TEST_BYTE) begin
            n_fail++;
            $display("FAIL %s_rx_leds got=%h/%h exp=%h", name, rx_data, leds, TEST_BYTE);
        end
        last_good = TEST_BYTE;
        loop_en = 1'b0;
    endtask

    task automatic test_driven_rx(input logic [7:0] b, input string name);
        got_q.delete();
        drive_frame(b, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        last_good = b;
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== b) begin
            n_fail++;
            $display("FAIL %s_rx count=%0d got=%h exp=%h", name, got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
        end
        n_checks++;
        if (rx_data !== last_good || leds !== last_good) begin
            n_fail++;
            $display("FAIL %s_hold got=%h/%h exp=%h", name, rx_data, leds, last_good);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic       ok;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'($urandom));
            drive_frame(exp_q[i], 1'b1);
        end
        repeat (2 * CPB) @(negedge clk);
        ok = (got_q.size() == 3);
        for (int i = 0; i < 3 && ok; i++) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL back_to_back count=%0d exp=3 first got=%h exp=%h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
        last_good = exp_q[2];
        n_checks++;
        if (leds !== last_good) begin n_fail++; $display("FAIL b2b_leds got=%h exp=%h", leds, last_good); end
    endtask

    task automatic test_framing_and_glitch();
        got_q.delete();
        drive_frame(8'($urandom), 1'b0);
        drv_rxd = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL framing_valid got=%0d exp=0", got_q.size()); end
        n_checks++;
        if (leds !== last_good || rx_data !== last_good) begin
            n_fail++;
            $display("FAIL framing_hold got=%h/%h exp=%h", rx_data, leds, last_good);
        end
        drv_rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_valid got=%0d exp=0", got_q.size()); end
        test_driven_rx(8'($urandom), "recover");
    endtask

    task automatic test_reset_mid_frame();
        logic quiet;
        loop_en = 1'b1;
        got_q.delete();
        key1 = 1'b1;
        repeat (2) @(negedge clk);
        key1 = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_tx txd/busy got=%b/%b exp=1/0", txd, tx_busy);
        end
        last_good = 8'h00;
        n_checks++;
        if (leds !== last_good || rx_data !== last_good) begin
            n_fail++;
            $display("FAIL midreset_rx got=%h/%h exp=00", rx_data, leds);
        end
        quiet = 1'b1;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet got=valid%0d exp=0 idle", got_q.size());
        end
        loop_en = 1'b0;
        test_loopback_send(-1, "after_reset");
    endtask

    task automatic test_pulse_width();
        n_checks++;
        if (long_pulses != 0) begin
            n_fail++;
            $display("FAIL valid_pulse_width got=%0d long pulses exp=0", long_pulses);
        end
    endtask

    initial begin
        test_reset();
        repeat (10) @(negedge clk);
        test_loopback_send(-1, "loopback");
        test_loopback_send(2 * CPB, "press_busy");
        test_driven_rx(8'h3C, "driven_3c");
        for (int i = 0; i < 4; i++) test_driven_rx(8'($urandom), "driven_rand");
        test_back_to_back();
        test_framing_and_glitch();
        test_reset_mid_frame();
        test_pulse_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
